fetch_ctrl: RTL

//  Front-end fetch sequencer: selects the next fetch PC from four sources (backend flush, branch

---
 rtl/front_pkg.sv | 32 +++
 rtl/fetch_npc_sel.sv | 46 ++++
 rtl/fetch_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/front_pkg.sv
// Shared front-end types and constants for the fetch sequencer.
package front_pkg;

    localparam int unsigned FETCH_WIDTH = 2;
    localparam logic [31:0] RESET_PC    = 32'h1c00_0000;
    localparam logic [6:0]  ECODE_ADEF  = 7'h08;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        WAIT
    } fetch_state_t;

    typedef logic [FETCH_WIDTH-1:0] slot_en_t;

    localparam slot_en_t SLOT0_ONLY = slot_en_t'(1);

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

    // Slot enables that follow from the address alone: slot1 would cross the
    // 8-byte fetch group, or the PC is misaligned and only carries the ADEF.
    function automatic slot_en_t pc_slot_base(input logic [31:0] pc);
        if (pc_misaligned(pc) || pc[2]) begin
            return SLOT0_ONLY;
        end
        return '1;
    endfunction

endpackage

// File: rtl/fetch_npc_sel.sv
// Next-PC priority mux (flush > mispredict > predicted-taken > sequential)
// and final slot-enable generation for the current fetch PC.
module fetch_npc_sel
    import front_pkg::*;
(
    input  logic [31:0]            fetch_pc,
    input  logic [FETCH_WIDTH-1:0] slot_base,
    input  logic                   iuncache,
    input  logic [FETCH_WIDTH-1:0] pred_taken,
    input  logic [31:0]            pred_addr,
    input  logic                   flush,
    input  logic [31:0]            flush_pc,
    input  logic                   mispredict,
    input  logic [31:0]            mispredict_pc,
    output logic [FETCH_WIDTH-1:0] inst_en,
    output logic                   redirect,
    output logic [31:0]            redirect_pc,
    output logic [31:0]            accept_pc
);

    logic        pred_hit;
    logic [31:0] seq_pc;

    always_comb begin
        inst_en = slot_base;
        if (iuncache || pred_taken[0]) begin
            inst_en = slot_base & SLOT0_ONLY;
        end
    end

    // A prediction only redirects when it lands in a slot actually being fetched.
    assign pred_hit    = |(pred_taken & inst_en);
    assign seq_pc      = fetch_pc + ((inst_en == '1) ? 32'd8 : 32'd4);
    assign redirect    = flush | mispredict;
    assign redirect_pc = flush ? flush_pc : mispredict_pc;

    always_comb begin
        accept_pc = seq_pc;
        if (redirect) begin
            accept_pc = redirect_pc;
        end else if (pred_hit) begin
            accept_pc = pred_addr;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Front-end fetch sequencer: issues one icache request at a time, follows
// redirects in any state and drops responses that belong to a squashed PC.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = front_pkg::RESET_PC,
    parameter logic [6:0]  ECODE_ADEF = front_pkg::ECODE_ADEF
) (
    input  logic                              cpu_clk,
    input  logic                              cpu_rst,
    input  logic                              flush,
    input  logic [31:0]                       flush_pc,
    input  logic                              mispredict,
    input  logic [31:0]                       mispredict_pc,
    input  logic [front_pkg::FETCH_WIDTH-1:0] pred_taken,
    input  logic [31:0]                       pred_addr,
    input  logic                              iuncache,
    input  logic                              buffer_full,
    input  logic                              icache_ready,
    input  logic                              icache_rvalid,
    output logic                              fetch_req,
    output logic [31:0]                       fetch_pc,
    output logic [front_pkg::FETCH_WIDTH-1:0] inst_en,
    output logic                              is_exception,
    output logic [6:0]                        exception_cause,
    output logic                              resp_valid,
    output logic                              if_valid
);

    import front_pkg::*;

    fetch_state_t         state;
    logic [31:0]          next_pc_q;
    logic                 stale;
    logic [FETCH_WIDTH-1:0] slot_base;
    logic                 redirect;
    logic [31:0]          redirect_pc;
    logic [31:0]          accept_pc;
    logic [31:0]          pc_d;

    fetch_npc_sel u_npc_sel (
        .fetch_pc      (fetch_pc),
        .slot_base     (slot_base),
        .iuncache      (iuncache),
        .pred_taken    (pred_taken),
        .pred_addr     (pred_addr),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .mispredict    (mispredict),
        .mispredict_pc (mispredict_pc),
        .inst_en       (inst_en),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .accept_pc     (accept_pc)
    );

    // A redirecting cycle never hands the old PC to the icache.
    assign fetch_req  = (state == REQ) && !buffer_full && !redirect;
    assign if_valid   = fetch_req && icache_ready;
    assign resp_valid = (state == WAIT) && icache_rvalid && !stale && !redirect;

    // fetch_pc holds the in-flight PC during WAIT; the successor waits in
    // next_pc_q so the address-derived attributes can be registered with it.
    always_comb begin
        pc_d = fetch_pc;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if ((state == WAIT) && icache_rvalid) begin
            pc_d = next_pc_q;
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state           <= IDLE;
            fetch_pc        <= RESET_PC;
            next_pc_q       <= RESET_PC;
            stale           <= 1'b0;
            slot_base       <= '0;
            is_exception    <= 1'b0;
            exception_cause <= '0;
        end else begin
            fetch_pc        <= pc_d;
            slot_base       <= pc_slot_base(pc_d);
            is_exception    <= pc_misaligned(pc_d);
            exception_cause <= pc_misaligned(pc_d) ? ECODE_ADEF : '0;

            case (state)
                IDLE: begin
                    state <= REQ;
                end
                REQ: begin
                    if (redirect) begin
                        state <= REQ;
                    end else if (buffer_full) begin
                        state <= HOLD;
                    end else if (if_valid) begin
                        next_pc_q <= accept_pc;
                        state     <= WAIT;
                    end
                end
                HOLD: begin
                    if (redirect || !buffer_full) begin
                        state <= REQ;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        next_pc_q <= redirect_pc;
                        stale     <= !icache_rvalid;
                        state     <= icache_rvalid ? REQ : WAIT;
                    end else if (icache_rvalid) begin
                        stale <= 1'b0;
                        state <= REQ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
